mpmc10_rd_strip_asm: RTL

Read-strip assembler for the mpmc10 multi-port memory controller. Memory returns a burst read as a series of strips. This block counts the returned strips, packs them into one wide line, and holds the completed line for the requesting port's read cache until it is acknowledged. It sits directly downstream of the request strip counter and the memory interface's read-data path.

---
 rtl/mpmc10_rd_strip_asm.sv | 102 ++++++++++
 1 files changed

// File: rtl/mpmc10_rd_strip_asm.sv
// mpmc10 read-strip assembler: collects a burst of memory strips
// into one wide line and holds it until the read cache acks it.
module mpmc10_rd_strip_asm #(
  parameter int STRIP_W    = 128,
  parameter int MAX_STRIPS = 4,
  parameter int TAG_W      = 4
) (
  input  logic                          rst,
  input  logic                          clk,
  input  logic                          start,
  input  logic [5:0]                    num_strips,
  input  logic [TAG_W-1:0]              tag_i,
  input  logic                          rd_data_valid,
  input  logic [STRIP_W-1:0]            rd_data,
  output logic [STRIP_W*MAX_STRIPS-1:0] line_o,
  output logic [TAG_W-1:0]              tag_o,
  output logic                          line_vld,
  input  logic                          line_ack,
  output logic                          busy,
  output logic [5:0]                    strip_cnt,
  output logic                          err_ovf
);

  localparam logic [5:0] LAST_MAX = 6'(MAX_STRIPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic [STRIP_W*MAX_STRIPS-1:0] line_q;
  logic [TAG_W-1:0]              tag_q;
  logic [5:0]                    cnt_q;
  logic [5:0]                    last_q;
  logic                          err_q;
  logic [5:0]                    slot;
  logic                          at_last;

  // MAX_STRIPS is a power of two, so masking keeps the low index bits
  assign slot    = cnt_q & LAST_MAX;
  assign at_last = (cnt_q == last_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (rd_data_valid && at_last) state_d = HOLD;
      HOLD:    if (line_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (rd_data_valid) err_q <= 1'b1;
          if (start) begin
            tag_q  <= tag_i;
            line_q <= '0;
            cnt_q  <= '0;
            if (num_strips > LAST_MAX) begin
              last_q <= LAST_MAX;
              err_q  <= 1'b1;
            end else begin
              last_q <= num_strips;
            end
          end
        end
        COLLECT: begin
          if (rd_data_valid) begin
            line_q[int'(slot)*STRIP_W +: STRIP_W] <= rd_data;
            if (!at_last) cnt_q <= cnt_q + 6'd1;
          end
        end
        HOLD: begin
          if (rd_data_valid) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign line_o    = line_q;
  assign tag_o     = tag_q;
  assign line_vld  = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign strip_cnt = cnt_q;
  assign err_ovf   = err_q;

endmodule
